// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, parity encodings and baud divider helper.
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  function automatic int calc_div(input longint clk_hz, input longint baud);
    return int'(clk_hz / (baud * 16));
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks, restartable via clr.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver with parity/stop checks and a
// single-word valid/ready output buffer.
module uart_rx import uart_pkg::*; #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  if (DIV < 1) begin : g_div_chk
    $error("uart_rx: CLK_HZ/(BAUD*16) must be at least 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_chk
    $error("uart_rx: DATA_BITS must be 5..8");
  end
  rx_state_t state;
  logic s1, s2, s3;
  logic tick, clr, fall, decide, bit_v;
  logic [3:0] cnt16;
  logic [1:0] samp;
  logic [2:0] bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic par_bad;
  // s3 is only a delayed copy for edge detection, so a line stuck low
  // never re-triggers a frame until it has gone high again.
  assign fall   = s3 & ~s2;
  assign clr    = state == S_IDLE && fall;
  assign decide = tick && cnt16 == 4'd8;
  assign bit_v  = (samp[0] & samp[1]) | (samp[0] & s2) | (samp[1] & s2);
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .clr(clr), .tick(tick));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s3, s2, s1} <= 3'b111;
      state <= S_IDLE;
      cnt16 <= '0;
      samp <= '0;
      bit_cnt <= '0;
      sh <= '0;
      par_bad <= 1'b0;
      m_data <= '0;
      m_valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, rxd};
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (tick && state != S_IDLE) begin
        cnt16 <= cnt16 + 4'd1;
        if (cnt16 == 4'd6) samp[0] <= s2;
        if (cnt16 == 4'd7) samp[1] <= s2;
      end
      case (state)
        S_IDLE: if (fall) begin
          state <= S_START;
          cnt16 <= '0;
        end
        S_START: if (decide) begin
          state <= bit_v ? S_IDLE : S_DATA;
          bit_cnt <= '0;
          par_bad <= 1'b0;
        end
        S_DATA: if (decide) begin
          sh <= {bit_v, sh[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state <= PARITY == PAR_NONE ? S_STOP : S_PARITY;
        end
        S_PARITY: if (decide) begin
          par_bad <= bit_v != (^sh ^ (PARITY == PAR_ODD));
          state <= S_STOP;
        end
        S_STOP: if (decide) begin
          state <= S_IDLE;
          frame_err <= ~bit_v;
          parity_err <= par_bad;
          if (bit_v && !par_bad) begin
            if (!m_valid || m_ready) begin
              m_data <= sh;
              m_valid <= 1'b1;
            end else overrun <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx (8N1 and 8E1 instances).
module tb_uart_rx;
  logic clk = 0, rst = 1;
  logic rxd_n = 1, rxd_e = 1, rdy_n = 1, rdy_e = 1;
  logic [7:0] data_n, data_e;
  logic val_n, val_e, fe_n_o, fe_e_o, pe_n_o, pe_e_o, ov_n_o, ov_e_o;
  int checks = 0, errors = 0, cyc = 0, fall_cyc = 0;
  int hs_n = 0, hs_e = 0, fe_n = 0, pe_e = 0, ov_n = 0, other = 0;
  int vcnt_n = 0, vcyc_n = 0, fe_cyc_n = 0, vcyc_e = 0;
  logic val_n_q = 0, val_e_q = 0;
  logic [7:0] q_n[$], q_e[$];

  uart_rx #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0)) u_n (
    .clk(clk), .rst(rst), .rxd(rxd_n), .m_data(data_n), .m_valid(val_n), .m_ready(rdy_n),
    .frame_err(fe_n_o), .parity_err(pe_n_o), .overrun(ov_n_o));
  uart_rx #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2)) u_e (
    .clk(clk), .rst(rst), .rxd(rxd_e), .m_data(data_e), .m_valid(val_e), .m_ready(rdy_e),
    .frame_err(fe_e_o), .parity_err(pe_e_o), .overrun(ov_e_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (val_n && !val_n_q) vcyc_n = cyc;
      if (val_e && !val_e_q) vcyc_e = cyc;
      if (val_n) vcnt_n++;
      if (val_n && rdy_n) begin
        hs_n++;
        check("n_data", {24'd0, data_n}, q_n.size() != 0 ? {24'd0, q_n.pop_front()} : 'x);
      end
      if (val_e && rdy_e) begin
        hs_e++;
        check("e_data", {24'd0, data_e}, q_e.size() != 0 ? {24'd0, q_e.pop_front()} : 'x);
      end
      if (fe_n_o) begin fe_n++; fe_cyc_n = cyc; end
      if (ov_n_o) ov_n++;
      if (pe_e_o) pe_e++;
      if (pe_n_o || fe_e_o || ov_e_o) other++;
    end
    val_n_q = val_n;
    val_e_q = val_e;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting at the current (posedge+1) phase; skew stretches odd bits by a cycle.
  task automatic send(input bit e, input logic [7:0] d, input bit par_en, input bit par,
                      input bit stop, input bit skew);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_en) bits.push_back(par);
    bits.push_back(stop);
    foreach (bits[i]) begin
      if (e) rxd_e = bits[i]; else rxd_n = bits[i];
      if (i == 0) fall_cyc = cyc;
      repeat (16 + int'(skew && i % 2 == 1)) @(posedge clk);
      #1;
    end
    if (e) rxd_e = 1'b1; else rxd_n = 1'b1;
  endtask

  initial begin
    int f, h;
    idle(3);
    check("rst_n_valid", {31'd0, val_n}, 0);
    check("rst_n_data", {24'd0, data_n}, 0);
    check("rst_n_errs", {29'd0, fe_n_o, pe_n_o, ov_n_o}, 0);
    check("rst_e_valid", {31'd0, val_e}, 0);
    check("rst_e_errs", {29'd0, fe_e_o, pe_e_o, ov_e_o}, 0);
    rst = 0;
    idle(5);
    // 8N1 latency and single-cycle valid
    vcnt_n = 0;
    q_n.push_back(8'hA5);
    send(0, 8'hA5, 0, 0, 1, 0);
    f = fall_cyc;
    idle(10);
    check("a5_latency", vcyc_n - f, 156);
    check("a5_valid_width", vcnt_n, 1);
    check("a5_handshakes", hs_n, 1);
    // even parity good then bad
    q_e.push_back(8'h3C);
    send(1, 8'h3C, 1, 0, 1, 0);
    f = fall_cyc;
    idle(10);
    check("par_good_hs", hs_e, 1);
    check("par_latency", vcyc_e - f, 172);
    send(1, 8'h3C, 1, 1, 1, 0);
    idle(10);
    check("par_bad_pulse", pe_e, 1);
    check("par_bad_hs", hs_e, 1);
    // frame error then recovery
    send(0, 8'h55, 0, 0, 0, 0);
    f = fall_cyc;
    idle(10);
    check("fe_pulse", fe_n, 1);
    check("fe_timing", fe_cyc_n - f, 156);
    check("fe_no_word", hs_n, 1);
    q_n.push_back(8'h12);
    send(0, 8'h12, 0, 0, 1, 0);
    idle(10);
    check("after_fe_hs", hs_n, 2);
    // overrun with consumer stalled
    rdy_n = 0;
    q_n.push_back(8'h11);
    send(0, 8'h11, 0, 0, 1, 0);
    send(0, 8'h22, 0, 0, 1, 0);
    idle(5);
    check("ov_pulse", ov_n, 1);
    check("ov_hold_data", {24'd0, data_n}, 32'h11);
    check("ov_hold_valid", {31'd0, val_n}, 1);
    rdy_n = 1;
    idle(2);
    check("ov_drained_valid", {31'd0, val_n}, 0);
    check("ov_drained_hs", hs_n, 3);
    // glitch rejection
    h = hs_n;
    rxd_n = 0;
    idle(6);
    rxd_n = 1;
    idle(40);
    check("glitch_no_word", hs_n, h);
    check("glitch_no_err", fe_n, 1);
    // slow transmitter
    q_n.push_back(8'hFF);
    send(0, 8'hFF, 0, 0, 1, 1);
    idle(10);
    check("skew_hs", hs_n, h + 1);
    // reset mid-frame
    fork
      send(0, 8'h81, 0, 0, 1, 0);
      begin
        idle(60);
        rst = 1;
        #1;
        check("midrst_valid", {31'd0, val_n}, 0);
        check("midrst_data", {24'd0, data_n}, 0);
      end
    join
    idle(3);
    rst = 0;
    idle(20);
    q_n.push_back(8'h42);
    send(0, 8'h42, 0, 0, 1, 0);
    idle(10);
    check("post_rst_hs", hs_n, h + 2);
    check("q_n_empty", q_n.size(), 0);
    check("q_e_empty", q_e.size(), 0);
    check("ov_total", ov_n, 1);
    check("fe_total", fe_n, 1);
    check("stray_pulses", other, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
